// File: rtl/imem_pkg.sv
// imem_pkg: shared state type, NOP constant and index-width helper for the instruction-memory arbiter
package imem_pkg;

    typedef enum logic {BOOT, RUN} imem_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Width of a word index into a RAM of mem_size words (mem_size a power of two)
    function automatic int idx_width(input int mem_size);
        return $clog2(mem_size);
    endfunction

endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: owns the single instruction-RAM port, sharing it between fetch and the program loader
//
// Ports:
//   CLK, reset              clock and synchronous active-high reset
//   PCF, FetchReq           fetch byte address and request
//   StallF                  fetch requested but not granted this cycle
//   InstrF, FetchValid,     one-cycle-late fetch response; NOP with FetchErr
//   FetchErr                when the fetched word was out of range
//   LdValid, LdAddr,        loader write request; LdReady acknowledges it
//   LdData, LdReady
//   LdDone                  end-of-image pulse, releases the core from BOOT
//   CoreRun                 high once the core is running
//   MemA, MemWD, MemWE,     RAM port; MemRD is valid one cycle after a read
//   MemRD
//
// Build option: define IMEM_RUNTIME_WRITE_EN to let the loader patch words in RUN
// (fetch has priority, starvation-bounded by STARVE_LIMIT). Without it the loader
// may only write in BOOT.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int MEM_SIZE     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        FetchReq,
    output logic        StallF,
    output logic [31:0] InstrF,
    output logic        FetchValid,
    output logic        FetchErr,
    input  logic        LdValid,
    input  logic [31:0] LdAddr,
    input  logic [31:0] LdData,
    output logic        LdReady,
    input  logic        LdDone,
    output logic        CoreRun,
    output logic [31:0] MemA,
    output logic [31:0] MemWD,
    output logic        MemWE,
    input  logic [31:0] MemRD
);

    localparam int         IDX_W = idx_width(MEM_SIZE);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
`ifdef IMEM_RUNTIME_WRITE_EN
    localparam bit RT_WRITE = 1'b1;
`else
    localparam bit RT_WRITE = 1'b0;
`endif

    imem_state_t state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_oor_q, rsp_oor_d;
    logic        core_run_q;
    logic        ld_grant, f_grant, ld_in_range, f_in_range;

    // A byte address is in range when every word-index bit above IDX_W is zero
    function automatic logic in_range(input logic [31:0] a);
        return (a >> (IDX_W + 2)) == 32'd0;
    endfunction

    always_comb begin
        ld_in_range = in_range(LdAddr);
        f_in_range  = in_range(PCF);
        // Nothing is granted while reset is asserted so the RAM is never written then
        ld_grant    = !reset && LdValid &&
                      (state_q == BOOT || (RT_WRITE && (!FetchReq || starve_q == LIMIT)));
        f_grant     = !reset && state_q == RUN && FetchReq && !ld_grant;
        starve_d    = (RT_WRITE && state_q == RUN && LdValid && !ld_grant) ?
                      ((starve_q == LIMIT) ? starve_q : starve_q + 8'd1) : 8'd0;
        state_d     = (state_q == BOOT && LdDone) ? RUN : state_q;
        rsp_valid_d = f_grant;
        rsp_oor_d   = f_grant && !f_in_range;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= BOOT;
            starve_q    <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_oor_q   <= 1'b0;
            core_run_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_oor_q   <= rsp_oor_d;
            core_run_q  <= (state_d == RUN);
        end
    end

    assign LdReady    = ld_grant;
    assign StallF     = FetchReq && !f_grant;
    assign MemA       = ld_grant ? LdAddr : (f_grant ? PCF : 32'd0);
    assign MemWD      = ld_grant ? LdData : 32'd0;
    // Out-of-range loader writes are acknowledged but never reach the RAM
    assign MemWE      = ld_grant && ld_in_range;
    assign CoreRun    = core_run_q;
    assign FetchValid = rsp_valid_q;
    assign FetchErr   = rsp_valid_q && rsp_oor_q;
    assign InstrF     = (rsp_valid_q && !rsp_oor_q) ? MemRD : NOP_INSTR;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Controller that owns the single port of the synchronous instruction RAM and shares it between the core's fetch stage and the program loader. After reset it holds the core in BOOT while the loader writes the program image. It then releases the core to RUN, where fetch has priority and a bounded-starvation rule lets the loader patch words. It sits between the fetch stage/loader and the instruction RAM, and presents a word-aligned read with one cycle of latency to fetch.

## Interface
Parameters:
- MEM_SIZE, 32: RAM depth in 32-bit words. Must be a power of two, ≥2.
- STARVE_LIMIT, 4: number of consecutive denied loader cycles in RUN before the loader is forced a slot. Range 1..255.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- PCF  in  32  fetch byte address. Bits [1:0] ignored.
- FetchReq  in  1  fetch request this cycle.
- StallF  out  1  fetch not granted this cycle (combinational).
- InstrF  out  32  fetched instruction, meaningful when FetchValid.
- FetchValid  out  1  InstrF carries the response to last cycle's granted fetch.
- FetchErr  out  1  last granted fetch was out of range.
- LdValid  in  1  loader write request.
- LdAddr  in  32  loader byte address. Bits [1:0] ignored.
- LdData  in  32  loader write word.
- LdReady  out  1  loader write accepted this cycle (combinational).
- LdDone  in  1  end-of-image pulse.
- CoreRun  out  1  high in RUN.
- MemA  out  32  RAM byte address.
- MemWD  out  32  RAM write data.
- MemWE  out  1  RAM write enable.
- MemRD  in  32  RAM read data, valid one cycle after MemA with MemWE=0.

## Operation
- FSM states: BOOT, RUN.
  - reset → BOOT.
  - BOOT → RUN on LdDone=1.
  - RUN remains RUN until reset. LdDone is ignored in RUN.
- BOOT:
  - Loader grant = LdValid. Fetch grant = 0, so StallF=1 and CoreRun=0.
  - LdDone together with LdValid: the write is accepted, then the FSM goes to RUN.
- RUN:
  - Loader grant = LdValid && (!FetchReq || starve_cnt == STARVE_LIMIT).
  - Fetch grant = FetchReq && !loader grant.
  - StallF = FetchReq && !fetch grant.
- starve_cnt (8 bits), RUN only:
  - Increments, saturating at STARVE_LIMIT, each cycle LdValid=1 and the loader is denied.
  - Clears to 0 on loader grant, on LdValid=0, and in BOOT.
- Port mux:
  - Loader grant: MemA=LdAddr, MemWD=LdData, MemWE=1 if in range, else 0.
  - Fetch grant: MemA=PCF, MemWE=0.
  - Idle: MemA=0, MemWD=0, MemWE=0.
- In range means word index (address[31:2]) < MEM_SIZE.
  - Out-of-range loader write: acknowledged via LdReady and dropped.
  - Out-of-range fetch: returns NOP 0x00000013 with FetchErr=1.
- Response path:
  - Registered flags: rsp_valid (= fetch grant) and rsp_oor (= out-of-range fetch).
  - FetchValid=rsp_valid. FetchErr=rsp_valid&&rsp_oor.
  - InstrF=MemRD if rsp_valid&&!rsp_oor, else NOP.

## Timing
- Fetch latency: granted in cycle N, so InstrF/FetchValid in cycle N+1.
- Back-to-back fetches sustain one per cycle.
- Loader handshake: the transfer happens in a cycle with LdValid&&LdReady.
  - The loader must hold LdAddr/LdData stable while LdValid=1 && LdReady=0.
- Worst-case loader wait in RUN under continuous FetchReq: STARVE_LIMIT denied cycles, then a grant. The fetch is stalled on that grant cycle.
- Write-then-read of the same word: the fetch in the next cycle sees the new data. The RAM is write-first or sequential.
- Reset values, registered: state=BOOT, starve_cnt=0, rsp_valid=0, rsp_oor=0, CoreRun=0, FetchValid=0, FetchErr=0.
- Combinational outputs during the reset cycle: LdReady=0, MemWE=0, StallF=FetchReq.
- Reset mid-operation: the in-flight response is discarded, so FetchValid=0 in the next cycle, and the FSM returns to BOOT.

## Configuration
- IMEM_RUNTIME_WRITE_EN defined: the RUN loader-slot rules above apply.
- Undefined:
  - In RUN, loader grant=0, LdReady=0, and starve_cnt is held at 0.
  - The loader can write only in BOOT. Fetch grant = FetchReq in RUN, so StallF=0 in RUN.

## Structure
- Shared package imem_pkg:
  - typedef enum logic {BOOT, RUN} imem_state_t.
  - localparam NOP_INSTR = 32'h00000013.
  - word-index width derived from MEM_SIZE via $clog2.
- No sub-module. The FSM, starvation counter and port mux form one module. The RAM is instantiated alongside, in the fetch-stage wrapper.

## Test plan
- Reset, then loader writes 0x00500093 to addr 0x0 and 0x00A00113 to 0x4, then LdDone → two MemWE pulses, CoreRun=1 the next cycle, StallF=1 throughout BOOT.
- RUN, FetchReq with PCF=0x0,0x4 on consecutive cycles → FetchValid in the following two cycles with InstrF=0x00500093, 0x00A00113. StallF=0.
- RUN, FetchReq held high, LdValid raised at cycle t with STARVE_LIMIT=4 → LdReady=0 on t..t+3, LdReady=1 and StallF=1 at t+4, starve_cnt=0 at t+5.
- PCF=4*MEM_SIZE → next cycle FetchValid=1, FetchErr=1, InstrF=0x00000013. Loader write to the same address → LdReady=1, MemWE=0.
- reset asserted the cycle after a granted fetch → FetchValid=0, CoreRun=0, state BOOT.
- IMEM_RUNTIME_WRITE_EN undefined, LdValid=1 in RUN for 10 cycles → LdReady=0 throughout, MemWE=0.
